// File: rtl/tdc_input_pkg.sv
// tdc_input_pkg: shared state encoding, defaults and width helper for the TDC hit input stage
package tdc_input_pkg;
  typedef enum logic [1:0] {ARMED, HOLD, CLEAR, DEAD} chState_t;
  localparam int DEF_N_CH = 4;
  localparam int DEF_PULSE_W = 2;
  localparam int DEF_DEAD_W = 8;
  localparam int DEF_CNT_W = 16;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tdc_hit_launch_cell.sv
// tdc_hit_launch_cell: hit-clocked launch flop with clk-domain clear and a 2-FF sync of its output
(* keep_hierarchy = "yes", dont_touch = "true" *)
module tdc_hit_launch_cell (
  input  logic clk,
  input  logic iRst,
  input  logic iHit,
  input  logic iClr,
  output logic oQ,
  output logic oQs
);
  logic [1:0] sync;
  always_ff @(posedge iHit or posedge iClr)
    if (iClr) oQ <= 1'b0;
    else oQ <= 1'b1;
  always_ff @(posedge clk)
    if (iRst) sync <= '0;
    else sync <= {sync[0], oQ};
  assign oQs = sync[1];
endmodule

// File: rtl/tdc_hit_input_mc.sv
// tdc_hit_input_mc: multi-channel TDC hit launch with per-channel arm, pulse, dead time and counting
module tdc_hit_input_mc
  import tdc_input_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int DEAD_W = DEF_DEAD_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  iRst,
  input  logic [N_CH-1:0]       iHit,
  input  logic [N_CH-1:0]       iEnable,
  output logic [N_CH-1:0]       oHit,
  output logic [N_CH-1:0]       oValid,
  output logic [N_CH-1:0]       oDrop,
  output logic [N_CH-1:0]       oBusy,
  output logic [N_CH*CNT_W-1:0] oCount
);
  localparam int PW = clog2(PULSE_W + 1);
  localparam int DW = clog2(DEAD_W + 1);
  localparam logic [PW-1:0] PLOAD = PW'(PULSE_W - 1);
  localparam logic [DW-1:0] DLOAD = DW'(DEAD_W - 1);
  for (genvar i = 0; i < N_CH; i++) begin : gCh
    chState_t state, nxt;
    logic [PW-1:0] pCnt;
    logic [DW-1:0] dCnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0] hs;
    logic hsD, clr, qs, en, hsRise, valid, drop, busy, accept;
    tdc_hit_launch_cell uCell (
      .clk (clk),
      .iRst(iRst),
      .iHit(iHit[i]),
      .iClr(clr),
      .oQ  (oHit[i]),
      .oQs (qs)
    );
    assign en = iEnable[i];
    assign hsRise = hs[1] & ~hsD;
    assign accept = state == ARMED && qs;
    // The launch flop is only released once both its output and the raw hit have settled low
    always_comb
      nxt = state == ARMED ? (!en ? CLEAR : qs ? HOLD : ARMED)
          : state == HOLD  ? ((!en || pCnt == '0) ? CLEAR : HOLD)
          : state == CLEAR ? ((!qs && !hs[1]) ? DEAD : CLEAR)
          : ((dCnt == '0 && en) ? ARMED : DEAD);
    always_ff @(posedge clk)
      if (iRst) begin
        state <= DEAD;
        pCnt  <= '0;
        dCnt  <= DLOAD;
        cnt   <= '0;
        hs    <= '0;
        hsD   <= 1'b0;
        clr   <= 1'b1;
        valid <= 1'b0;
        drop  <= 1'b0;
        busy  <= 1'b1;
      end else begin
        state <= nxt;
        pCnt  <= state == HOLD ? pCnt - PW'(1) : PLOAD;
        dCnt  <= state == DEAD ? dCnt - DW'(dCnt != '0) : DLOAD;
        cnt   <= cnt + CNT_W'(accept && cnt != '1);
        hs    <= {hs[0], iHit[i]};
        hsD   <= hs[1];
        clr   <= nxt == CLEAR || nxt == DEAD;
        valid <= accept;
        drop  <= en && hsRise && state != ARMED;
        busy  <= nxt != ARMED;
      end
    assign oValid[i] = valid;
    assign oDrop[i] = drop;
    assign oBusy[i] = busy;
    assign oCount[i*CNT_W +: CNT_W] = cnt;
  end
endmodule
